// File: rtl/simple_add.sv
// Registered valid/ready unsigned adder/subtractor with one-entry skid buffer.
// Optional macro SIMPLE_ADD_CARRY_CNT_EN adds a 16-bit carry/borrow result counter.
module simple_add #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    input  logic                  op,
    input  logic                  in_valid,
    output logic                  in_ready,
`ifdef SIMPLE_ADD_CARRY_CNT_EN
    output logic [15:0]           carry_cnt,
`endif
    output logic [DATA_WIDTH:0]   c,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned RES_W = DATA_WIDTH + 1;

    logic [RES_W-1:0] r_c;
    logic             r_out_valid;
    logic [RES_W-1:0] r_skid_c;
    logic             r_skid_valid;
    logic             r_in_ready;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [RES_W-1:0] w_a_ext;
    logic [RES_W-1:0] w_b_ext;
    logic [RES_W-1:0] w_cin_ext;
    logic [RES_W-1:0] w_result;
    logic [RES_W-1:0] w_c_nxt;
    logic             w_out_valid_nxt;
    logic [RES_W-1:0] w_skid_c_nxt;
    logic             w_skid_valid_nxt;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // One extra bit of width holds the carry; in subtract it becomes the borrow
    // because the two's-complement difference never drops below -2^DATA_WIDTH.
    assign w_a_ext   = RES_W'(a);
    assign w_b_ext   = RES_W'(b);
    assign w_cin_ext = RES_W'(cin);

    always_comb begin
        w_result = w_a_ext + w_b_ext + w_cin_ext;
        if (op) begin
            w_result = w_a_ext - w_b_ext - w_cin_ext;
        end
    end

    // Output register refills from skid first to preserve ordering.
    always_comb begin
        w_c_nxt          = r_c;
        w_out_valid_nxt  = r_out_valid;
        w_skid_c_nxt     = r_skid_c;
        w_skid_valid_nxt = r_skid_valid;
        if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                w_c_nxt          = r_skid_c;
                w_out_valid_nxt  = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_xfer) begin
                w_c_nxt         = w_result;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end else if (w_in_xfer) begin
            w_skid_c_nxt     = w_result;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_c          <= '0;
            r_out_valid  <= 1'b0;
            r_skid_c     <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_c          <= w_c_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_skid_c     <= w_skid_c_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

`ifdef SIMPLE_ADD_CARRY_CNT_EN
    logic [15:0] r_carry_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_carry_cnt <= '0;
        end else if (w_out_xfer && r_c[DATA_WIDTH]) begin
            r_carry_cnt <= r_carry_cnt + 16'd1;
        end
    end

    assign carry_cnt = r_carry_cnt;
`else
    logic w_unused;
    assign w_unused = w_out_xfer;
`endif

    assign c         = r_c;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_simple_add.sv
// Directed self-checking bench for simple_add (8-bit default width).
module tb_simple_add;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       op;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] c;
    logic       out_valid;
    logic       out_ready;
`ifdef SIMPLE_ADD_CARRY_CNT_EN
    logic [15:0] carry_cnt;
`endif

    int n_checks;
    int n_fail;

    simple_add #(.DATA_WIDTH(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef SIMPLE_ADD_CARRY_CNT_EN
        .carry_cnt (carry_cnt),
`endif
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_cc(input string name, input int exp_cnt);
`ifdef SIMPLE_ADD_CARRY_CNT_EN
        n_checks++;
        if (carry_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s carry_cnt got %0d expected %0d", name, carry_cnt, exp_cnt);
        end
`else
        if (name.len() < 0 || exp_cnt < 0) $display("unused");
`endif
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'd1; b = 8'd1; cin = 1'b0; op = 1'b0;
        step();
        step();
        n_checks++;
        if (c !== 9'h000 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold c=%h ov=%b ir=%b expected c=000 ov=0 ir=1", c, out_valid, in_ready);
        end
        check_cc("reset_hold", 0);
        sys_rst_n = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release ov=%b expected 0", out_valid);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || c !== 9'd2) begin
            n_fail++;
            $display("FAIL reset_first ov=%b c=%h expected ov=1 c=002", out_valid, c);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drain ov=%b expected 0", out_valid);
        end
    endtask

    task automatic test_add_stream();
        logic [8:0] exp_c;
        out_ready = 1'b1;
        op = 1'b0; cin = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i); b = 8'(i);
            exp_c = 9'(2 * i);
            step();
            n_checks++;
            if (out_valid !== 1'b1 || c !== exp_c || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL add_stream[%0d] c=%h ov=%b ir=%b expected c=%h ov=1 ir=1", i, c, out_valid, in_ready, exp_c);
            end
        end
        n_checks++;
        if (c[8] !== 1'b1 || c !== 9'h1FE) begin
            n_fail++;
            $display("FAIL add_stream_max c=%h expected 1fe", c);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_stream_drain ov=%b expected 0", out_valid);
        end
        check_cc("add_stream", 128);
    endtask

    task automatic test_boundary();
        out_ready = 1'b1;
        op = 1'b0;
        in_valid = 1'b1;
        a = 8'd255; b = 8'd255; cin = 1'b1;
        step();
        n_checks++;
        if (c !== 9'h1FF || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL add_max c=%h ov=%b expected 1ff ov=1", c, out_valid);
        end
        a = 8'd0; b = 8'd0; cin = 1'b0;
        step();
        n_checks++;
        if (c !== 9'h000 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL add_zero c=%h ov=%b expected 000 ov=1", c, out_valid);
        end
        in_valid = 1'b0;
        step();
        check_cc("boundary", 129);
    endtask

    task automatic test_subtract();
        out_ready = 1'b1;
        op = 1'b1;
        in_valid = 1'b1;
        a = 8'd5; b = 8'd7; cin = 1'b0;
        step();
        n_checks++;
        if (c !== 9'h1FE || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_borrow c=%h ov=%b expected 1fe ov=1", c, out_valid);
        end
        a = 8'd7; b = 8'd5; cin = 1'b1;
        step();
        n_checks++;
        if (c !== 9'h001 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_cin c=%h ov=%b expected 001 ov=1", c, out_valid);
        end
        a = 8'd0; b = 8'd255; cin = 1'b1;
        step();
        n_checks++;
        if (c !== 9'h100) begin
            n_fail++;
            $display("FAIL sub_min c=%h expected 100", c);
        end
        in_valid = 1'b0;
        step();
        check_cc("subtract", 131);
    endtask

    task automatic test_back_to_back();
        op = 1'b0; cin = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 8'd1; b = 8'd1;
        step();
        n_checks++;
        if (c !== 9'd2 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first c=%h ov=%b ir=%b expected 002 1 1", c, out_valid, in_ready);
        end
        a = 8'd2; b = 8'd2;
        step();
        n_checks++;
        if (c !== 9'd2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_skid c=%h ov=%b ir=%b expected 002 1 0", c, out_valid, in_ready);
        end
        a = 8'd3; b = 8'd3;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (c !== 9'd2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] c=%h ov=%b ir=%b expected 002 1 0", k, c, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (c !== 9'd4 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_unskid c=%h ov=%b ir=%b expected 004 1 1", c, out_valid, in_ready);
        end
        step();
        n_checks++;
        if (c !== 9'd6 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_third c=%h ov=%b expected 006 1", c, out_valid);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain ov=%b ir=%b expected 0 1", out_valid, in_ready);
        end
        check_cc("back_to_back", 131);
    endtask

    task automatic test_reset_mid_stall();
        op = 1'b0; cin = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 8'd200; b = 8'd100;
        step();
        a = 8'd10; b = 8'd20;
        step();
        n_checks++;
        if (c !== 9'h12C || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_full c=%h ov=%b ir=%b expected 12c 1 0", c, out_valid, in_ready);
        end
        in_valid = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || c !== 9'h000) begin
            n_fail++;
            $display("FAIL stall_reset ov=%b ir=%b c=%h expected 0 1 000", out_valid, in_ready, c);
        end
        check_cc("stall_reset", 0);
        step();
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_after ov=%b expected 0 (no stale result)", out_valid);
        end
        in_valid = 1'b1;
        a = 8'd128; b = 8'd128;
        step();
        in_valid = 1'b0;
        step();
        check_cc("post_reset_carry", 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sys_rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0; op = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_add_stream();
        test_boundary();
        test_subtract();
        test_back_to_back();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
